// File: rtl/qmem_ratio_ctrl_pkg.sv
// Shared definitions for the QMEM clock-ratio change sequencer.
// State encoding is kept as plain 2-bit constants for compatibility with legacy code.
package qmem_ratio_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DRAIN  = 2'd1;
  localparam state_t ST_REQ    = 2'd2;
  localparam state_t ST_SETTLE = 2'd3;

endpackage

// File: rtl/qmem_ratio_timer.sv
// Loadable down-counter shared by the drain/request timeouts and the settle delay.
// expire flags the decrement that takes the count from 1 to 0.
module qmem_ratio_timer #(
  parameter int CW = 8
) (
  input  logic          qm_clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] value,
  output logic          expire
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge qm_clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value  = cnt_q;
  assign expire = dec && !load && (cnt_q == CW'(1));

endmodule

// File: rtl/qmem_ratio_ctrl.sv
// Master-side sequencer for QMEM clock-ratio changes: drains the bus, handshakes
// with the clock generator, applies the new ratio, settles, then reopens the bus.
module qmem_ratio_ctrl
  import qmem_ratio_ctrl_pkg::*;
#(
  parameter int RW        = 3,
  parameter int CW        = 8,
  parameter int TO_CYC    = 200,
  parameter int SET_CYC   = 4,
  parameter int RATIO_RST = 0
) (
  input  logic          qm_clk,
  input  logic          rst,
  input  logic [RW-1:0] cfg_ratio,
  input  logic          cfg_req,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic [RW-1:0] ratio,
  output logic          ratio_req,
  input  logic          ratio_grt,
  input  logic          m_cs,
  input  logic          m_we,
  output logic          s_cs,
  output logic          s_we,
  input  logic          s_ack,
  output logic          m_ack
);

  state_t        state_q, state_d;
  logic [RW-1:0] ratio_q, ratio_d;
  logic [RW-1:0] new_q, new_d;
  logic          gate_q, gate_d;
  logic          ratio_req_q, ratio_req_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          tmr_load;
  logic [CW-1:0] tmr_load_val;
  logic          tmr_dec;
  logic [CW-1:0] tmr_value;
  logic          tmr_expire;

  qmem_ratio_timer #(.CW(CW)) u_timer (
    .qm_clk   (qm_clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .expire   (tmr_expire)
  );

  logic boundary;
  assign boundary = ~m_cs | s_ack;

  always_comb begin
    state_d      = state_q;
    ratio_d      = ratio_q;
    new_d        = new_q;
    gate_d       = gate_q;
    ratio_req_d  = ratio_req_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = CW'(TO_CYC);
    tmr_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_req) begin
          if (cfg_ratio == ratio_q) begin
            done_d = 1'b1;
          end else begin
            new_d    = cfg_ratio;
            tmr_load = 1'b1;
            state_d  = ST_DRAIN;
          end
        end
      end
      // Boundary and grant take priority over a timeout expiring in the same cycle.
      ST_DRAIN: begin
        if (boundary) begin
          gate_d      = 1'b1;
          ratio_req_d = 1'b1;
          tmr_load    = 1'b1;
          state_d     = ST_REQ;
        end else begin
          tmr_dec = 1'b1;
          if (tmr_expire) begin
            gate_d      = 1'b0;
            ratio_req_d = 1'b0;
            err_d       = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_REQ: begin
        if (ratio_grt) begin
          ratio_d      = new_q;
          tmr_load     = 1'b1;
          tmr_load_val = CW'(SET_CYC);
          state_d      = ST_SETTLE;
        end else begin
          tmr_dec = 1'b1;
          if (tmr_expire) begin
            gate_d      = 1'b0;
            ratio_req_d = 1'b0;
            err_d       = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: begin
        tmr_dec = 1'b1;
        if (tmr_value == CW'(1)) begin
          gate_d      = 1'b0;
          ratio_req_d = 1'b0;
          done_d      = 1'b1;
          state_d     = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge qm_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ratio_q     <= RW'(RATIO_RST);
      new_q       <= RW'(RATIO_RST);
      gate_q      <= 1'b0;
      ratio_req_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ratio_q     <= ratio_d;
      new_q       <= new_d;
      gate_q      <= gate_d;
      ratio_req_q <= ratio_req_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign cfg_busy  = (state_q != ST_IDLE);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;
  assign ratio     = ratio_q;
  assign ratio_req = ratio_req_q;
  assign s_cs      = m_cs & ~gate_q;
  assign s_we      = m_we & ~gate_q;
  assign m_ack     = s_ack & ~gate_q;

endmodule
